// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
// Holds the sequence states, latched source encoding and default vector addresses.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_P,
        VEC_LO,
        VEC_HI
    } seq_state_e;

    typedef enum logic [1:0] {
        NONE,
        IRQ,
        NMI,
        RST
    } int_src_e;

    localparam logic [1:0] DSEL_PCH  = 2'd0;
    localparam logic [1:0] DSEL_PCL  = 2'd1;
    localparam logic [1:0] DSEL_P    = 2'd2;
    localparam logic [1:0] DSEL_NONE = 2'd3;

    localparam logic [15:0] DEFAULT_NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] DEFAULT_IRQ_VECTOR   = 16'hFFFE;

endpackage

// File: rtl/interrupt_source_latch.sv
// Priority-encodes the injector source flags and holds the result for a whole
// interrupt entry sequence.
module interrupt_source_latch
    import interrupt_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       enable_i,
    input  logic       capture_i,
    input  logic       reset_i,
    input  logic       nmi_i,
    input  logic       irq_i,
    output logic [1:0] src_o
);

    int_src_e src_q, src_d;

    // A pending interrupt with no flag set is treated as an IRQ.
    always_comb begin
        src_d = src_q;
        if (enable_i && capture_i) begin
            if (reset_i)      src_d = RST;
            else if (nmi_i)   src_d = NMI;
            else if (irq_i)   src_d = IRQ;
            else              src_d = IRQ;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) src_q <= NONE;
        else       src_q <= src_d;
    end

    assign src_o = src_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Takes over the control path at an instruction boundary to run the interrupt
// entry sequence: push PCH, PCL, P, then fetch the vector low/high bytes.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] NMI_VECTOR   = DEFAULT_NMI_VECTOR,
    parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [15:0] IRQ_VECTOR   = DEFAULT_IRQ_VECTOR
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        enableFFs,
    input  logic        pendingInterrupt,
    input  logic        nmiGenerated,
    input  logic        irqGenerated,
    input  logic        resetDetected,
    input  logic        instructionBoundary,
    output logic        interruptStarted,
    output logic        seqActive,
    output logic        stackWrite,
    output logic        stackDecrement,
    output logic [1:0]  dataOutSel,
    output logic        setIFlag,
    output logic [15:0] vectorAddr,
    output logic        loadPCL,
    output logic        loadPCH
);

    seq_state_e  state_q, state_d;
    logic [1:0]  latched_src;
    logic        trigger;
    logic        is_reset;
    logic [15:0] vec_lo;

    assign trigger = (state_q == IDLE) && pendingInterrupt && instructionBoundary;

    interrupt_source_latch u_src_latch (
        .clk       (clk),
        .nrst      (nrst),
        .enable_i  (enableFFs),
        .capture_i (trigger),
        .reset_i   (resetDetected),
        .nmi_i     (nmiGenerated),
        .irq_i     (irqGenerated),
        .src_o     (latched_src)
    );

    assign is_reset = (latched_src == RST);

    always_comb begin
        case (latched_src)
            RST:     vec_lo = RESET_VECTOR;
            NMI:     vec_lo = NMI_VECTOR;
            default: vec_lo = IRQ_VECTOR;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (enableFFs) begin
            case (state_q)
                IDLE:     if (trigger) state_d = PUSH_PCH;
                PUSH_PCH: state_d = PUSH_PCL;
                PUSH_PCL: state_d = PUSH_P;
                PUSH_P:   state_d = VEC_LO;
                VEC_LO:   state_d = VEC_HI;
                VEC_HI:   state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Pulses are qualified by enableFFs so a stalled cycle never repeats an action.
    always_comb begin
        seqActive        = (state_q != IDLE);
        interruptStarted = 1'b0;
        stackWrite       = 1'b0;
        stackDecrement   = 1'b0;
        dataOutSel       = DSEL_NONE;
        setIFlag         = 1'b0;
        vectorAddr       = '0;
        loadPCL          = 1'b0;
        loadPCH          = 1'b0;
        case (state_q)
            PUSH_PCH: begin
                dataOutSel     = DSEL_PCH;
                stackWrite     = enableFFs && !is_reset;
                stackDecrement = enableFFs;
            end
            PUSH_PCL: begin
                dataOutSel     = DSEL_PCL;
                stackWrite     = enableFFs && !is_reset;
                stackDecrement = enableFFs;
            end
            PUSH_P: begin
                dataOutSel       = DSEL_P;
                stackWrite       = enableFFs && !is_reset;
                stackDecrement   = enableFFs;
                setIFlag         = enableFFs;
                interruptStarted = enableFFs;
            end
            VEC_LO: begin
                vectorAddr = vec_lo;
                loadPCL    = enableFFs;
            end
            VEC_HI: begin
                vectorAddr = vec_lo + 16'd1;
                loadPCH    = enableFFs;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with a queue of expected output vectors.
module tb_interrupt_sequencer;

    logic        clk;
    logic        nrst;
    logic        enableFFs;
    logic        pendingInterrupt;
    logic        nmiGenerated;
    logic        irqGenerated;
    logic        resetDetected;
    logic        instructionBoundary;
    logic        interruptStarted;
    logic        seqActive;
    logic        stackWrite;
    logic        stackDecrement;
    logic [1:0]  dataOutSel;
    logic        setIFlag;
    logic [15:0] vectorAddr;
    logic        loadPCL;
    logic        loadPCH;

    typedef struct packed {
        logic        act;
        logic        started;
        logic        wr;
        logic        dec;
        logic [1:0]  sel;
        logic        seti;
        logic [15:0] vec;
        logic        lpcl;
        logic        lpch;
    } obs_t;

    obs_t        exp_q[$];
    int unsigned pass_cnt    = 0;
    int unsigned total_cnt   = 0;
    int unsigned started_cnt = 0;

    interrupt_sequencer dut (
        .clk                 (clk),
        .nrst                (nrst),
        .enableFFs           (enableFFs),
        .pendingInterrupt    (pendingInterrupt),
        .nmiGenerated        (nmiGenerated),
        .irqGenerated        (irqGenerated),
        .resetDetected       (resetDetected),
        .instructionBoundary (instructionBoundary),
        .interruptStarted    (interruptStarted),
        .seqActive           (seqActive),
        .stackWrite          (stackWrite),
        .stackDecrement      (stackDecrement),
        .dataOutSel          (dataOutSel),
        .setIFlag            (setIFlag),
        .vectorAddr          (vectorAddr),
        .loadPCL             (loadPCL),
        .loadPCH             (loadPCH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ph: 0=IDLE, 1=PUSH_PCH, 2=PUSH_PCL, 3=PUSH_P, 4=VEC_LO, 5=VEC_HI; src: 0=IRQ, 1=NMI, 2=reset
    function automatic obs_t model(int ph, int src, logic en);
        obs_t        m;
        logic [15:0] v;
        v = (src == 2) ? 16'hFFFC : (src == 1) ? 16'hFFFA : 16'hFFFE;
        m = '0;
        m.sel = 2'd3;
        m.act = (ph != 0);
        if (ph >= 1 && ph <= 3) begin
            m.sel = 2'(ph - 1);
            m.dec = en;
            m.wr  = en && (src != 2);
        end
        if (ph == 3) begin
            m.started = en;
            m.seti    = en;
        end
        if (ph == 4) begin
            m.vec  = v;
            m.lpcl = en;
        end
        if (ph == 5) begin
            m.vec  = v + 16'd1;
            m.lpch = en;
        end
        return m;
    endfunction

    function automatic obs_t observe();
        return {seqActive, interruptStarted, stackWrite, stackDecrement, dataOutSel,
                setIFlag, vectorAddr, loadPCL, loadPCH};
    endfunction

    task automatic compare(string tag);
        obs_t e;
        obs_t o;
        e = exp_q.pop_front();
        o = observe();
        if (o.started) started_cnt++;
        total_cnt++;
        assert (o === e) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, o, e);
    endtask

    task automatic step(int ph, int src, string tag);
        exp_q.push_back(model(ph, src, enableFFs));
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic check_int(string tag, int got, int expv);
        total_cnt++;
        assert (got == expv) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, got, expv);
    endtask

    // Inputs for the trigger edge must already be driven by the caller.
    task automatic run_seq(int src, string name, int nmi_drop_ph, int stall_ph, int b2b_ph);
        started_cnt = 0;
        for (int ph = 1; ph <= 5; ph++) begin
            step(ph, src, $sformatf("%s_ph%0d", name, ph));
            if (ph == 1) begin
                instructionBoundary = 1'b0;
                pendingInterrupt    = 1'b0;
            end
            if (ph == nmi_drop_ph) nmiGenerated = 1'b0;
            if (ph == b2b_ph) begin
                nmiGenerated        = 1'b1;
                pendingInterrupt    = 1'b1;
                instructionBoundary = 1'b1;
            end
            if (ph == stall_ph) begin
                enableFFs = 1'b0;
                step(ph, src, $sformatf("%s_stall_a", name));
                step(ph, src, $sformatf("%s_stall_b", name));
                enableFFs = 1'b1;
            end
        end
        step(0, src, $sformatf("%s_idle", name));
        check_int($sformatf("%s_started_count", name), int'(started_cnt), 1);
    endtask

    initial begin
        nrst                = 1'b0;
        enableFFs           = 1'b1;
        pendingInterrupt    = 1'b0;
        nmiGenerated        = 1'b0;
        irqGenerated        = 1'b0;
        resetDetected       = 1'b0;
        instructionBoundary = 1'b0;
        #1;
        exp_q.push_back(model(0, 0, 1'b1));
        compare("reset_state");
        #12 nrst = 1'b1;

        instructionBoundary = 1'b1;
        step(0, 0, "idle_no_pending_a");
        step(0, 0, "idle_no_pending_b");

        irqGenerated     = 1'b1;
        pendingInterrupt = 1'b1;
        run_seq(0, "irq", 0, 0, 0);
        irqGenerated = 1'b0;

        resetDetected       = 1'b1;
        pendingInterrupt    = 1'b1;
        instructionBoundary = 1'b1;
        run_seq(2, "rstsrc", 0, 0, 0);
        resetDetected = 1'b0;

        nmiGenerated        = 1'b1;
        irqGenerated        = 1'b1;
        pendingInterrupt    = 1'b1;
        instructionBoundary = 1'b1;
        run_seq(1, "prio", 2, 0, 0);
        irqGenerated = 1'b0;

        irqGenerated        = 1'b1;
        pendingInterrupt    = 1'b1;
        instructionBoundary = 1'b1;
        run_seq(0, "clken", 0, 2, 0);

        // NMI raised during an IRQ sequence waits for VEC_HI -> IDLE, then is taken.
        pendingInterrupt    = 1'b1;
        instructionBoundary = 1'b1;
        run_seq(0, "b2b_irq", 0, 0, 3);
        irqGenerated = 1'b0;
        run_seq(1, "b2b_nmi", 0, 0, 0);
        nmiGenerated        = 1'b0;
        instructionBoundary = 1'b0;

        irqGenerated     = 1'b1;
        pendingInterrupt = 1'b1;
        for (int i = 0; i < 10; i++) step(0, 0, $sformatf("nobnd_wait%0d", i));
        instructionBoundary = 1'b1;
        run_seq(0, "nobnd", 0, 0, 0);

        pendingInterrupt    = 1'b1;
        instructionBoundary = 1'b1;
        started_cnt         = 0;
        step(1, 0, "midrst_ph1");
        pendingInterrupt    = 1'b0;
        instructionBoundary = 1'b0;
        step(2, 0, "midrst_ph2");
        step(3, 0, "midrst_ph3");
        #2 nrst = 1'b0;
        #1;
        exp_q.push_back(model(0, 0, 1'b1));
        compare("midrst_async");
        step(0, 0, "midrst_hold");
        #4 nrst = 1'b1;
        step(0, 0, "midrst_after_a");
        step(0, 0, "midrst_after_b");
        step(0, 0, "midrst_after_c");
        check_int("midrst_started_count", int'(started_cnt), 1);
        check_int("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
